onehot_rr_selector: RTL and testbench

- Sequential round-robin selector that sits directly upstream of the 64-to-6 one-hot encoder in the mdclcg_ufa datapath.
- Samples a 64-bit request vector and emits one registered, strictly one-hot grant per transfer. The encoder turns that grant into a 6-bit index.
- Rotating priority gives fair service to all request lines. A valid/ready handshake lets the downstream stage stall the grant.

---
 rtl/onehot_rr_selector.sv | 88 ++++++++
 tb/tb_onehot_rr_selector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_selector.sv
// Round-robin request selector feeding the 64-to-6 one-hot encoder.
// Emits a registered one-hot grant with a valid/ready handshake. Priority
// rotates to the line just above the most recently accepted grant.
module onehot_rr_selector #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic         idle
);

    localparam logic [N-1:0] One     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] LastRst = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] grant_q, grant_d;
    logic [N-1:0] last_q, last_d;
    logic         valid_q, valid_d;

    logic         accept;
    logic         load;
    logic [N-1:0] base;
    logic [N-1:0] above;
    logic [N-1:0] req_hi;
    logic [N-1:0] sel;

    assign accept = valid_q & grant_ready;
    assign load   = en & (~valid_q | grant_ready);
    assign base   = accept ? grant_q : last_q;

    // Rotated priority pick: the lowest request strictly above the base bit
    // wins; if there is none, the search wraps to the lowest request overall.
    // Equivalent to a double-width mask-and-priority search.
    always_comb begin
        above  = ~(base | (base - One));
        req_hi = req & above;
        if (req_hi != '0) begin
            sel = req_hi & (~req_hi + One);
        end else begin
            sel = req & (~req + One);
        end
    end

    // Next-state for grant, valid and the last-accepted pointer.
    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (accept) begin
            last_d = grant_q;
        end
        if (load) begin
            if (req != '0) begin
                grant_d = sel;
                valid_d = 1'b1;
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        end else if (accept) begin
            // Disabled but the held grant was consumed: go empty.
            grant_d = '0;
            valid_d = 1'b0;
        end
    end

    // State registers; reset leaves bit 63 as the pointer so bit 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            last_q  <= LastRst;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign idle        = ~valid_q & (req == '0);

endmodule

// File: tb/tb_onehot_rr_selector.sv
// Self-checking bench for onehot_rr_selector: directed vector table, fairness
// sweep, asynchronous reset check and randomized run against a reference model.
module tb_onehot_rr_selector;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [63:0] req;
    logic [63:0] grant;
    logic        grant_valid;
    logic        grant_ready;
    logic        idle;

    int checks;
    int errors;

    // Reference model state: index-based, independent of RTL encoding.
    bit m_valid;
    int m_gidx;
    int m_last;

    onehot_rr_selector #(.N(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rdy;
        logic [63:0] req;
        logic [63:0] exp_grant;
        logic        exp_valid;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [63:0] b(int i);
        logic [63:0] v;
        v = 64'd1;
        return v << i;
    endfunction

    // First requesting line scanning upward from base+1, wrapping; -1 if none.
    function automatic int pick(int base_idx, logic [63:0] r);
        for (int k = 1; k <= 64; k++) begin
            if (r[(base_idx + k) % 64]) return (base_idx + k) % 64;
        end
        return -1;
    endfunction

    function automatic logic [63:0] m_grant();
        return m_valid ? b(m_gidx) : 64'd0;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_gidx  = 0;
        m_last  = 63;
    endtask

    // Apply inputs, clock once, advance the model, leave time at edge+1.
    task automatic cycle(logic e, logic r, logic [63:0] rq);
        bit acc;
        bit ld;
        int base;
        int p;
        en          = e;
        grant_ready = r;
        req         = rq;
        @(posedge clk);
        acc  = m_valid && r;
        ld   = e && (!m_valid || r);
        base = acc ? m_gidx : m_last;
        if (acc) m_last = m_gidx;
        if (ld) begin
            p = pick(base, rq);
            if (p >= 0) begin
                m_valid = 1'b1;
                m_gidx  = p;
            end else begin
                m_valid = 1'b0;
            end
        end else if (acc) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en          = 1'b0;
        grant_ready = 1'b0;
        req         = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] rq;
        logic        e;
        logic        r;
        logic        exp_idle;

        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        // Directed table, applied from a fresh reset (pointer at bit 63).
        tbl[0]  = '{1'b1, 1'b1, b(0),          b(0),  1'b1};
        tbl[1]  = '{1'b1, 1'b1, b(0),          b(0),  1'b1};
        tbl[2]  = '{1'b1, 1'b1, b(0) | b(63),  b(63), 1'b1};
        tbl[3]  = '{1'b1, 1'b1, b(0) | b(63),  b(0),  1'b1};
        tbl[4]  = '{1'b1, 1'b1, b(0) | b(63),  b(63), 1'b1};
        tbl[5]  = '{1'b1, 1'b1, b(62),         b(62), 1'b1};
        tbl[6]  = '{1'b1, 1'b1, b(62) | b(63), b(63), 1'b1};
        tbl[7]  = '{1'b1, 1'b1, b(62) | b(63), b(62), 1'b1};
        tbl[8]  = '{1'b1, 1'b1, b(5),          b(5),  1'b1};
        tbl[9]  = '{1'b1, 1'b0, b(2) | b(40),  b(5),  1'b1};
        tbl[10] = '{1'b1, 1'b0, b(2) | b(40),  b(5),  1'b1};
        tbl[11] = '{1'b1, 1'b0, b(2) | b(40),  b(5),  1'b1};
        tbl[12] = '{1'b1, 1'b0, b(2) | b(40),  b(5),  1'b1};
        tbl[13] = '{1'b1, 1'b1, b(2) | b(40),  b(40), 1'b1};
        tbl[14] = '{1'b1, 1'b1, b(2) | b(40),  b(2),  1'b1};
        tbl[15] = '{1'b0, 1'b1, b(7),          64'd0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, b(7),          b(7),  1'b1};
        tbl[17] = '{1'b0, 1'b0, 64'd0,         b(7),  1'b1};
        tbl[18] = '{1'b1, 1'b1, 64'd0,         64'd0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, b(9),          b(9),  1'b1};

        do_reset();
        #1;
        chk("reset_grant", grant, 64'd0);
        chk("reset_valid", {63'd0, grant_valid}, 64'd0);
        chk("reset_idle", {63'd0, idle}, 64'd1);

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].en, tbl[i].rdy, tbl[i].req);
            exp_idle = !tbl[i].exp_valid && (tbl[i].req == 64'd0);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].exp_grant);
            chk($sformatf("tbl%0d_valid", i), {63'd0, grant_valid}, {63'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_idle", i), {63'd0, idle}, {63'd0, exp_idle});
        end

        // Fairness sweep: all lines requesting, grants must walk 0..63 and wrap.
        do_reset();
        for (int i = 0; i < 130; i++) begin
            cycle(1'b1, 1'b1, {64{1'b1}});
            chk($sformatf("fair%0d", i), grant, b(i % 64));
        end

        // Async reset mid-cycle while bit 20 is granted.
        do_reset();
        cycle(1'b1, 1'b1, b(20));
        chk("pre_rst_grant", grant, b(20));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 64'd0);
        chk("async_rst_valid", {63'd0, grant_valid}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, b(20) | b(3));
        chk("post_rst_grant", grant, b(3));
        cycle(1'b1, 1'b1, b(20) | b(3));
        chk("post_rst_grant2", grant, b(20));

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: rq = 64'd0;
                1: rq = b($urandom_range(0, 63)) | b($urandom_range(0, 63));
                2: rq = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: rq = {$urandom, $urandom};
            endcase
            e = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(e, r, rq);
            chk($sformatf("rnd%0d_grant", i), grant, m_grant());
            chk($sformatf("rnd%0d_valid", i), {63'd0, grant_valid}, {63'd0, m_valid});
            chk($sformatf("rnd%0d_idle", i), {63'd0, idle},
                {63'd0, (!m_valid && rq == 64'd0)});
            chk($sformatf("rnd%0d_onehot0", i), {63'd0, $onehot0(grant)}, 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
